// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg
//   Shared definitions for the buffered UART transmitter: frame FSM state
//   encodings, 8N1 frame constants and the bit-period helper.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  localparam int FRAME_DATA_BITS = 8;
  localparam int FRAME_STOP_BITS = 1;

  // Clock cycles per line bit, integer truncation.
  function automatic int calc_divisor(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with registered occupancy count. Pushes while full and
//   pops while empty are ignored. The head entry is presented combinationally
//   so the consumer can load it on the same edge that it pops.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_data     write request and data
//   pop                 remove head entry
//   head                current head entry (valid when empty = 0)
//   full, empty         derived from the registered count
module sync_fifo #(
  parameter int Width     = 8,
  parameter int DepthLog2 = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int Depth = 1 << DepthLog2;

  logic [Width-1:0]   mem [Depth];
  logic [DepthLog2-1:0] wr_ptr;
  logic [DepthLog2-1:0] rd_ptr;
  logic [DepthLog2:0]   count;
  logic                 push_ok;
  logic                 pop_ok;

  assign full    = (count == (DepthLog2 + 1)'(Depth));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; stale entries are never visible past count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are exactly DepthLog2 bits wide so they wrap modulo Depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Buffered 8N1 UART transmitter: bytes pushed into a sync_fifo are sent
//   LSB first with one start and one stop bit. Back-to-back frames follow
//   with no idle gap while the FIFO has data.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   wrEnable_i    push request for wrData_i (dropped when full)
//   wrData_i      byte to transmit
//   full_o        FIFO holds 2**FifoDepthLog2 bytes
//   empty_o       FIFO holds no bytes
//   busy_o        frame in progress or FIFO non-empty
//   overflow_o    sticky, set by a push attempted while full
//   txd_o         registered serial line, idle high
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line high, waiting for a byte in the FIFO
// ST_START | start bit (low) for one bit period
// ST_DATA  | shift_reg[0] on the line, eight bit periods, LSB first
// ST_STOP  | stop bit (high); chain straight into the next start if queued
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int ClkFrequency  = 25000000,
  parameter int Baud          = 9600,
  parameter int FifoDepthLog2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wrEnable_i,
  input  logic [7:0] wrData_i,
  output logic       full_o,
  output logic       empty_o,
  output logic       busy_o,
  output logic       overflow_o,
  output logic       txd_o
);

  localparam int Divisor = calc_divisor(ClkFrequency, Baud);
  localparam int CntW    = (Divisor > 1) ? $clog2(Divisor) : 1;
  localparam logic [CntW-1:0] CntReload = CntW'(Divisor - 1);
  localparam logic [2:0]      LastBit   = 3'(FRAME_DATA_BITS - 1);

  tx_state_e   state;
  logic [CntW-1:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        txd;
  logic        overflow;
  logic        baud_done;
  logic        pop;
  logic [7:0]  fifo_head;
  logic        fifo_full;
  logic        fifo_empty;

  sync_fifo #(
    .Width     (8),
    .DepthLog2 (FifoDepthLog2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wrEnable_i),
    .push_data (wrData_i),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign baud_done = (baud_cnt == '0);
  // Pop when idle, or at the last cycle of a stop bit, so the next start bit
  // begins on the very next cycle.
  assign pop = !fifo_empty &&
               ((state == ST_IDLE) || ((state == ST_STOP) && baud_done));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      txd       <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      if (wrEnable_i && fifo_full) overflow <= 1'b1;

      case (state)
        ST_IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shift_reg <= fifo_head;
            bit_cnt   <= '0;
            baud_cnt  <= CntReload;
            txd       <= 1'b0;
            state     <= ST_START;
          end
        end

        ST_START: begin
          if (baud_done) begin
            baud_cnt <= CntReload;
            txd      <= shift_reg[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        ST_DATA: begin
          if (baud_done) begin
            baud_cnt <= CntReload;
            if (bit_cnt == LastBit) begin
              txd   <= 1'b1;
              state <= ST_STOP;
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              shift_reg <= shift_reg >> 1;
              txd       <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        ST_STOP: begin
          if (baud_done) begin
            if (pop) begin
              shift_reg <= fifo_head;
              bit_cnt   <= '0;
              baud_cnt  <= CntReload;
              txd       <= 1'b0;
              state     <= ST_START;
            end else begin
              txd   <= 1'b1;
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        default: begin
          txd   <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign txd_o      = txd;
  assign overflow_o = overflow;
  assign full_o     = fifo_full;
  assign empty_o    = fifo_empty;
  assign busy_o     = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Scoreboard bench: bytes expected on the line are queued as they are
//   pushed; a line monitor captures every frame sample by sample and checks
//   it against the head of the queue.
module tb_uart_tx_fifo;

  localparam int DIV   = 16;
  localparam int FRAME = 10 * DIV;
  localparam int IDLE_MAX = 4000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, busy, ovf, txd;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int frames_seen = 0;
  int e0;

  logic [7:0] exp_q [$];
  int         start_q [$];

  logic mon_on = 1'b0;
  int   mon_t  = 0;
  logic smp [FRAME];

  uart_tx_fifo #(
    .ClkFrequency  (16),
    .Baud          (1),
    .FifoDepthLog2 (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wrEnable_i (wr_en),
    .wrData_i   (wr_data),
    .full_o     (full),
    .empty_o    (empty),
    .busy_o     (busy),
    .overflow_o (ovf),
    .txd_o      (txd)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  task automatic frame_done();
    logic [7:0] want;
    logic [7:0] got;
    logic       eb;
    int         bad;
    if (exp_q.size() == 0) begin
      check_val("unexpected_frame", 1, 0);
      return;
    end
    want = exp_q.pop_front();
    for (int i = 0; i < 8; i++) got[i] = smp[8 + DIV * (i + 1)];
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      eb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : want[k-1];
      for (int j = 0; j < DIV; j++)
        if (smp[DIV * k + j] !== eb) bad++;
    end
    check_val("frame_data", {24'd0, got}, {24'd0, want});
    check_val("frame_shape", bad, 0);
    frames_seen++;
  endtask

  // Line monitor: one sample per cycle at the falling clock edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      mon_on = 1'b0;
    end else if (!mon_on) begin
      if (txd === 1'b0) begin
        mon_on = 1'b1;
        mon_t  = 0;
        smp[0] = txd;
        start_q.push_back(cyc);
      end
    end else begin
      mon_t++;
      smp[mon_t] = txd;
      if (mon_t == FRAME - 1) begin
        frame_done();
        mon_on = 1'b0;
      end
    end
  end

  // Called at a falling edge; the push is sampled at the next rising edge and
  // the task returns at the falling edge after it.
  task automatic drive_push(input logic [7:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) exp_q.push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy === 1'b1 || mon_on) && n < IDLE_MAX) begin
      @(negedge clk);
      n++;
    end
    check_val("idle_reached", (n < IDLE_MAX) ? 1 : 0, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_txd", txd, 1);
    check_val("rst_empty", empty, 1);
    check_val("rst_full", full, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ovf", ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    // single byte, latency and idle afterwards
    start_q.delete();
    frames_seen = 0;
    drive_push(8'h55, 1);
    e0 = cyc;
    check_val("t1_txd_hold", txd, 1);
    check_val("t1_busy", busy, 1);
    check_val("t1_empty", empty, 0);
    @(negedge clk);
    check_val("t1_txd_fall", txd, 0);
    wait_idle();
    check_val("t1_frames", frames_seen, 1);
    check_val("t1_nstart", start_q.size(), 1);
    if (start_q.size() >= 1) check_val("t1_start_cyc", start_q[0], e0 + 1);
    check_val("t1_busy_end", busy, 0);
    check_val("t1_txd_end", txd, 1);

    // back-to-back frames
    start_q.delete();
    frames_seen = 0;
    drive_push(8'h01, 1);
    drive_push(8'h80, 1);
    wait_idle();
    check_val("t2_frames", frames_seen, 2);
    check_val("t2_nstart", start_q.size(), 2);
    if (start_q.size() >= 2) check_val("t2_gap", start_q[1] - start_q[0], FRAME);

    // 17 bytes fill FIFO exactly, one already in the shifter
    frames_seen = 0;
    for (int i = 0; i < 17; i++) drive_push(8'(i), 1);
    check_val("t3_full", full, 1);
    check_val("t3_ovf", ovf, 0);
    wait_idle();
    check_val("t3_frames", frames_seen, 17);
    check_val("t3_ovf_end", ovf, 0);
    check_val("t3_q_empty", exp_q.size(), 0);

    // 18th byte dropped, overflow sticky
    frames_seen = 0;
    for (int i = 0; i < 18; i++) drive_push(8'(8'h40 + i), i < 17);
    check_val("t4_ovf", ovf, 1);
    check_val("t4_full", full, 1);
    wait_idle();
    check_val("t4_frames", frames_seen, 17);
    check_val("t4_ovf_sticky", ovf, 1);
    do_reset();
    check_val("t4_ovf_cleared", ovf, 0);

    // push while full coincides with the stop-bit pop
    frames_seen = 0;
    drive_push(8'h20, 1);
    e0 = cyc;
    for (int i = 1; i < 17; i++) drive_push(8'(8'h20 + i), 1);
    while (cyc < e0 + FRAME) @(negedge clk);
    check_val("t5_full_before", full, 1);
    check_val("t5_ovf_before", ovf, 0);
    drive_push(8'hEE, 0);
    check_val("t5_ovf", ovf, 1);
    check_val("t5_full_after", full, 0);
    check_val("t5_empty_after", empty, 0);
    wait_idle();
    check_val("t5_frames", frames_seen, 17);
    do_reset();

    // reset mid-frame with bytes queued
    frames_seen = 0;
    drive_push(8'hA0, 1);
    e0 = cyc;
    for (int i = 1; i < 4; i++) drive_push(8'(8'hA0 + i), 1);
    while (cyc < e0 + 40) @(negedge clk);
    check_val("t6_empty_before", empty, 0);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_val("t6_txd", txd, 1);
    check_val("t6_empty", empty, 1);
    check_val("t6_busy", busy, 0);
    check_val("t6_full", full, 0);
    rst = 1'b0;
    begin
      int lows = 0;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (txd !== 1'b1) lows++;
      end
      check_val("t6_line_quiet", lows, 0);
    end
    check_val("t6_frames", frames_seen, 0);
    check_val("t6_busy_end", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter ClkFrequency, default 25000000, input clock frequency in Hz.
REQ-002 Parameter Baud, default 9600, line bit rate.
REQ-003 Parameter FifoDepthLog2, default 4, FIFO holds 2**FifoDepthLog2 bytes.
REQ-004 clk  input  1  single clock; one clock; reset is synchronous and active-high.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 wrEnable_i  input  1  push request for wrData_i.
REQ-007 wrData_i  input  8  byte to transmit.
REQ-008 full_o  output  1  FIFO holds 2**FifoDepthLog2 bytes.
REQ-009 empty_o  output  1  FIFO holds zero bytes.
REQ-010 busy_o  output  1  frame in progress or FIFO non-empty.
REQ-011 overflow_o  output  1  sticky: a push was attempted while full.
REQ-012 txd_o  output  1  serial line, 8N1, idle high.

Function
REQ-013 Bit period SHALL be Divisor = ClkFrequency/Baud clock cycles (integer truncation; 2604 at defaults).
REQ-014 A push SHALL be accepted on a rising edge where wrEnable_i=1 and full_o=0; otherwise the byte is dropped.
REQ-015 A push attempted with full_o=1 SHALL be dropped and set overflow_o=1 at that edge, even if a pop occurs in the same cycle.
REQ-016 full_o and empty_o SHALL be derived from a registered count; simultaneous accepted push and pop leaves count unchanged.
REQ-017 FIFO SHALL be first-in first-out; read and write pointers wrap modulo depth.
REQ-018 Frame FSM states: IDLE, START, DATA, STOP.
REQ-019 IDLE: txd_o=1; at an edge with empty_o=0, pop head byte into shift register, clear bit counter, enter START.
REQ-020 START: txd_o=0 for exactly Divisor cycles, then DATA.
REQ-021 DATA: drive shift register bit 0 (LSB first) for Divisor cycles each, 8 bits, then STOP.
REQ-022 STOP: txd_o=1 for Divisor cycles; at its end pop and enter START if FIFO non-empty (no idle gap), else IDLE.
REQ-023 Latency: with FSM in IDLE and FIFO empty, txd_o SHALL fall one cycle after the accepting edge of a push.
REQ-024 The baud counter SHALL restart at every state entry; frame length SHALL be exactly 10*Divisor cycles.
REQ-025 txd_o SHALL be registered (glitch-free).
REQ-026 busy_o SHALL equal (state != IDLE) OR (empty_o=0).

Reset
REQ-027 On rst=1 at an edge: state IDLE, txd_o=1, FIFO pointers and count 0, empty_o=1, full_o=0, busy_o=0, overflow_o=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame and return txd_o to 1 at that edge; queued bytes are discarded.
REQ-029 overflow_o SHALL clear only by reset.

Structure
REQ-030 Shared defines header SHALL carry the FSM state encodings and the 8N1 frame constants (data bits 8, stop bits 1).
REQ-031 FIFO SHALL be a sub-module named sync_fifo (parameterised width/depth, same clk/rst); FSM and baud counter stay in uart_tx_fifo.
REQ-032 Module SHALL be drop-in between serial_ctrl and the line, replacing the direct txdStart/txdData path.

Verification (bench uses ClkFrequency=16, Baud=1, Divisor=16)
REQ-033 Push 0x55 from reset-idle -> txd_o falls next cycle; line reads 0,1,0,1,0,1,0,1,0,1 at 16 cycles per bit; then idle high, busy_o=0.
REQ-034 Push 0x01, 0x80 back-to-back -> two frames of 160 cycles each, second start bit immediately after first stop bit, bits LSB first.
REQ-035 Push 17 bytes 0x00..0x10 in consecutive cycles -> first byte popped into FSM; full_o=1 after byte 0x10; no overflow; all 17 bytes transmitted in order.
REQ-036 Push 18 bytes consecutively -> 18th dropped, overflow_o=1 and stays 1 after line idles; 17 frames sent.
REQ-037 Assert rst at cycle 40 of a frame with 3 bytes queued -> txd_o=1 next edge, empty_o=1, busy_o=0, no further frames.
REQ-038 With FIFO full, push and internal pop in same cycle -> push dropped, overflow_o=1, count decrements by one.
